main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/main_control_fsm_if.sv | 35 +++
 rtl/main_control_out.sv | 63 ++++++
 rtl/main_control_fsm.sv | 66 ++++++
 tb/tb_main_control_fsm.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, FSM state
// codes, ALU/mux select encodings and the bundled control-word type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       alusrca;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       irwrite;
    logic       memwrite;
    logic       branch;
    logic       pcwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// Controller <-> datapath bundle: instruction/flag inputs, control outputs
// and the debug state code.
interface main_control_fsm_if;
  logic [5:0] op;
  logic       zero;
  // mem_ready: memory asserts it in the cycle an access completes; the
  // controller holds the requesting state (and its outputs) until it sees it.
  logic       mem_ready;
  logic       iord;
  logic       alusrca;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       irwrite;
  logic       memwrite;
  logic       branch;
  logic       pcwrite;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       pcen;
  logic [3:0] state;

  modport master (
    input  op, zero, mem_ready,
    output iord, alusrca, regdst, memtoreg, regwrite, irwrite, memwrite,
           branch, pcwrite, alusrcb, pcsrc, aluop, pcen, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  iord, alusrca, regdst, memtoreg, regwrite, irwrite, memwrite,
           branch, pcwrite, alusrcb, pcsrc, aluop, pcen, state
  );
endinterface

// File: rtl/main_control_out.sv
// Moore output decode for the main controller: state code (plus the memory
// handshake in FETCH) to the full datapath control word.
module main_control_out
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl         = '0;
    ctrl.alusrcb = SRCB_REG;
    ctrl.pcsrc   = PCSRC_ALU;
    ctrl.aluop   = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE:   ctrl.alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD:    ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB:   ctrl.regwrite = 1'b1;
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ;  // codes 12-15 drive an all-zero control word
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main controller: state register and next-state logic,
// with output decode delegated to main_control_out.
module main_control_fsm
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  main_control_fsm_if.master bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  main_control_out u_out (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Write strobes are masked by rst_n so nothing commits while reset is held,
  // even though FETCH would otherwise follow mem_ready.
  assign bus.iord     = ctrl.iord;
  assign bus.alusrca  = ctrl.alusrca;
  assign bus.regdst   = ctrl.regdst;
  assign bus.memtoreg = ctrl.memtoreg;
  assign bus.regwrite = ctrl.regwrite & rst_n;
  assign bus.irwrite  = ctrl.irwrite  & rst_n;
  assign bus.memwrite = ctrl.memwrite & rst_n;
  assign bus.branch   = ctrl.branch;
  assign bus.pcwrite  = ctrl.pcwrite  & rst_n;
  assign bus.alusrcb  = ctrl.alusrcb;
  assign bus.pcsrc    = ctrl.pcsrc;
  assign bus.aluop    = ctrl.aluop;
  assign bus.pcen     = rst_n & (ctrl.pcwrite | (ctrl.branch & bus.zero));
  assign bus.state    = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: per-instruction state walks checked
// against a queue of expected state codes, plus reset and branch cases.
module tb_main_control_fsm;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  main_control_fsm_if bus ();

  main_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: expected state per cycle, with the mem_ready to apply there
  logic [3:0] exp_q[$];
  logic       rdy_q[$];

  logic [1:0] snap_aluop[16];
  logic [1:0] snap_pcsrc[16];
  logic [1:0] snap_alusrcb[16];
  logic       snap_alusrca[16];
  logic       snap_regdst[16];
  logic       snap_memtoreg[16];
  logic       snap_pcen[16];
  logic       snap_branch[16];
  logic       snap_pcwrite[16];
  int         rw_cnt;
  int         mw_cnt;
  int         ir_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic r);
    exp_q.push_back(s);
    rdy_q.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks the queued states; starts and ends mid-cycle, away from the edge.
  task automatic run_seq(input string tag);
    logic [3:0] e;
    rw_cnt = 0;
    mw_cnt = 0;
    ir_cnt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      bus.mem_ready = rdy_q.pop_front();
      #1;
      check({tag, " state"}, 32'(bus.state), 32'(e));
      snap_aluop[e]    = bus.aluop;
      snap_pcsrc[e]    = bus.pcsrc;
      snap_alusrcb[e]  = bus.alusrcb;
      snap_alusrca[e]  = bus.alusrca;
      snap_regdst[e]   = bus.regdst;
      snap_memtoreg[e] = bus.memtoreg;
      snap_pcen[e]     = bus.pcen;
      snap_branch[e]   = bus.branch;
      snap_pcwrite[e]  = bus.pcwrite;
      rw_cnt += int'(bus.regwrite);
      mw_cnt += int'(bus.memwrite);
      ir_cnt += int'(bus.irwrite);
      if (exp_q.size() > 0) step();
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.op        = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #3;
    check("rst state",   32'(bus.state),   32'd0);
    check("rst irwrite", 32'(bus.irwrite), 32'd0);
    check("rst pcwrite", 32'(bus.pcwrite), 32'd0);
    check("rst pcen",    32'(bus.pcen),    32'd0);
    check("rst alusrcb", 32'(bus.alusrcb), 32'd1);
    step();
    step();
    #3;
    rst_n = 1'b1;

    // lw, no stalls: 5 cycles
    bus.op = 6'b100011;
    push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(4, 1); push(0, 1);
    run_seq("lw");
    check("lw memtoreg", 32'(snap_memtoreg[4]), 32'd1);
    check("lw regwrite cnt", 32'(rw_cnt), 32'd1);
    check("lw memwrite cnt", 32'(mw_cnt), 32'd0);
    check("lw irwrite cnt", 32'(ir_cnt), 32'd2);
    check("lw memadr alusrcb", 32'(snap_alusrcb[2]), 32'd2);
    check("decode alusrcb", 32'(snap_alusrcb[1]), 32'd3);

    // lw with one MEMRD stall cycle
    push(0, 1); push(1, 1); push(2, 1); push(3, 0); push(3, 1); push(4, 1); push(0, 1);
    run_seq("lw stall");
    check("lw stall regwrite cnt", 32'(rw_cnt), 32'd1);

    // R-type
    bus.op = 6'b000000;
    push(0, 1); push(1, 1); push(6, 1); push(7, 1); push(0, 1);
    run_seq("rtype");
    check("rtype exec aluop", 32'(snap_aluop[6]), 32'd2);
    check("rtype exec alusrca", 32'(snap_alusrca[6]), 32'd1);
    check("rtype aluwb regdst", 32'(snap_regdst[7]), 32'd1);
    check("rtype regwrite cnt", 32'(rw_cnt), 32'd1);

    // beq taken and not taken
    bus.op   = 6'b000100;
    bus.zero = 1'b1;
    push(0, 1); push(1, 1); push(8, 1); push(0, 1);
    run_seq("beq z1");
    check("beq z1 pcen", 32'(snap_pcen[8]), 32'd1);
    check("beq z1 pcsrc", 32'(snap_pcsrc[8]), 32'd1);
    check("beq z1 aluop", 32'(snap_aluop[8]), 32'd1);
    check("beq z1 branch", 32'(snap_branch[8]), 32'd1);
    check("beq z1 pcwrite", 32'(snap_pcwrite[8]), 32'd0);
    bus.zero = 1'b0;
    push(0, 1); push(1, 1); push(8, 1); push(0, 1);
    run_seq("beq z0");
    check("beq z0 pcen", 32'(snap_pcen[8]), 32'd0);

    // sw with two wait cycles in MEMWR
    bus.op = 6'b101011;
    push(0, 1); push(1, 1); push(2, 1); push(5, 0); push(5, 0); push(5, 1); push(0, 1);
    run_seq("sw");
    check("sw memwrite cnt", 32'(mw_cnt), 32'd3);
    check("sw regwrite cnt", 32'(rw_cnt), 32'd0);

    // addi with one FETCH wait cycle
    bus.op = 6'b001000;
    push(0, 0); push(0, 1); push(1, 1); push(9, 1); push(10, 1); push(0, 1);
    run_seq("addi");
    check("addi exec alusrcb", 32'(snap_alusrcb[9]), 32'd2);
    check("addi exec alusrca", 32'(snap_alusrca[9]), 32'd1);
    check("addi regwrite cnt", 32'(rw_cnt), 32'd1);
    check("addi irwrite cnt", 32'(ir_cnt), 32'd2);

    // jump
    bus.op = 6'b000010;
    push(0, 1); push(1, 1); push(11, 1); push(0, 1);
    run_seq("j");
    check("j pcsrc", 32'(snap_pcsrc[11]), 32'd2);
    check("j pcwrite", 32'(snap_pcwrite[11]), 32'd1);
    check("j pcen", 32'(snap_pcen[11]), 32'd1);

    // unknown opcode acts as a NOP
    bus.op = 6'b111111;
    push(0, 1); push(1, 1); push(0, 1);
    run_seq("nop");
    check("nop regwrite cnt", 32'(rw_cnt), 32'd0);
    check("nop memwrite cnt", 32'(mw_cnt), 32'd0);

    // asynchronous reset while in EXECUTE
    bus.op = 6'b000000;
    push(0, 1); push(1, 1); push(6, 1);
    run_seq("rst exec");
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst state", 32'(bus.state), 32'd0);
    check("async rst regwrite", 32'(bus.regwrite), 32'd0);
    check("async rst pcen", 32'(bus.pcen), 32'd0);
    check("async rst irwrite", 32'(bus.irwrite), 32'd0);
    step();
    check("held rst state", 32'(bus.state), 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    check("post rst state", 32'(bus.state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
